// File: rtl/calc_alu_sequencer_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// calc_alu_sequencer_pkg: shared width, opcodes and state encoding
// Rev 1.0
// ---------------------------------------------------------------------------
package calc_alu_sequencer_pkg;

    localparam int WIDTH = 8;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    localparam logic [WIDTH-1:0] DIV0_QUOTIENT = 8'hFF;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_EXEC = 3'd1,
        S_MUL  = 3'd2,
        S_DIV  = 3'd3,
        S_DONE = 3'd4
    } state_t;

endpackage : calc_alu_sequencer_pkg
`default_nettype wire

// File: rtl/calc_alu_sequencer_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// calc_alu_sequencer_if: command/result handshake plus external ALU link
// Rev 1.0
// ---------------------------------------------------------------------------
interface calc_alu_sequencer_if;
    import calc_alu_sequencer_pkg::*;

    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [WIDTH-1:0] cmd_a;
    logic [WIDTH-1:0] cmd_b;

    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic             alu_add_sub;
    logic [WIDTH-1:0] alu_sum;
    logic             alu_c8;
    logic             alu_alb;
    logic             alu_agb;
    logic             alu_aeb;

    logic             res_valid;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] remainder;
    logic             carry_ovf;
    logic             cmp_lt;
    logic             cmp_gt;
    logic             cmp_eq;
    logic             err_div0;
    logic             busy;

    // Front end together with the external ALU
    modport master (
        output cmd_valid, cmd_op, cmd_a, cmd_b,
        output alu_sum, alu_c8, alu_alb, alu_agb, alu_aeb,
        input  cmd_ready, alu_a, alu_b, alu_add_sub,
        input  res_valid, result, remainder, carry_ovf,
        input  cmp_lt, cmp_gt, cmp_eq, err_div0, busy
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_a, cmd_b,
        input  alu_sum, alu_c8, alu_alb, alu_agb, alu_aeb,
        output cmd_ready, alu_a, alu_b, alu_add_sub,
        output res_valid, result, remainder, carry_ovf,
        output cmp_lt, cmp_gt, cmp_eq, err_div0, busy
    );

endinterface : calc_alu_sequencer_if
`default_nettype wire

// File: rtl/calc_alu_sequencer_iter_counter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// calc_alu_sequencer_iter_counter: loadable up/down counter with zero flag
// Rev 1.0
// ---------------------------------------------------------------------------
module calc_alu_sequencer_iter_counter
    import calc_alu_sequencer_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             en_i,
    input  logic             up_i,
    output logic [WIDTH-1:0] count_o,
    output logic             zero_o
);

    logic [WIDTH-1:0] count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= load_val_i;
        end else if (en_i) begin
            count_q <= up_i ? count_q + WIDTH'(1) : count_q - WIDTH'(1);
        end
    end

    assign count_o = count_q;
    assign zero_o  = (count_q == '0);

endmodule : calc_alu_sequencer_iter_counter
`default_nettype wire

// File: rtl/calc_alu_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// calc_alu_sequencer: runs ADD/SUB/MUL/DIV on a shared external 8-bit ALU
// Rev 1.0
// ---------------------------------------------------------------------------
module calc_alu_sequencer
    import calc_alu_sequencer_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    calc_alu_sequencer_if.slave  bus
);

    state_t           state_q;
    logic [1:0]       op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] work_q;
    logic             ovf_q;

    logic             res_valid_q;
    logic [WIDTH-1:0] result_q;
    logic [WIDTH-1:0] rem_q;
    logic             carry_q;
    logic             lt_q;
    logic             gt_q;
    logic             eq_q;
    logic             div0_q;

    logic             accept;
    logic             cnt_load;
    logic [WIDTH-1:0] cnt_load_val;
    logic             cnt_en;
    logic             cnt_up;
    logic [WIDTH-1:0] cnt_count;
    logic             cnt_zero;

    assign bus.cmd_ready = (state_q == S_IDLE) && !reset;
    assign accept        = bus.cmd_valid && bus.cmd_ready;

    // MUL counts B down to zero; DIV counts the quotient up from zero
    calc_alu_sequencer_iter_counter u_iter_counter (
        .clk        (clk),
        .rst        (reset),
        .load_i     (cnt_load),
        .load_val_i (cnt_load_val),
        .en_i       (cnt_en),
        .up_i       (cnt_up),
        .count_o    (cnt_count),
        .zero_o     (cnt_zero)
    );

    always_comb begin
        cnt_load        = accept;
        cnt_load_val    = (bus.cmd_op == OP_MUL) ? bus.cmd_b : '0;
        cnt_up          = (state_q == S_DIV);
        cnt_en          = 1'b0;
        bus.alu_a       = '0;
        bus.alu_b       = '0;
        bus.alu_add_sub = 1'b0;
        case (state_q)
            S_EXEC: begin
                bus.alu_a       = a_q;
                bus.alu_b       = b_q;
                bus.alu_add_sub = op_q[0];
            end
            S_MUL: begin
                if (!cnt_zero) begin
                    bus.alu_a = work_q;
                    bus.alu_b = a_q;
                    cnt_en    = 1'b1;
                end
            end
            S_DIV: begin
                if (b_q != '0) begin
                    bus.alu_a       = work_q;
                    bus.alu_b       = b_q;
                    bus.alu_add_sub = 1'b1;
                    cnt_en          = !bus.alu_alb;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            work_q      <= '0;
            ovf_q       <= 1'b0;
            res_valid_q <= 1'b0;
            result_q    <= '0;
            rem_q       <= '0;
            carry_q     <= 1'b0;
            lt_q        <= 1'b0;
            gt_q        <= 1'b0;
            eq_q        <= 1'b0;
            div0_q      <= 1'b0;
        end else begin
            res_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        op_q     <= bus.cmd_op;
                        a_q      <= bus.cmd_a;
                        b_q      <= bus.cmd_b;
                        work_q   <= (bus.cmd_op == OP_DIV) ? bus.cmd_a : '0;
                        ovf_q    <= 1'b0;
                        result_q <= '0;
                        rem_q    <= '0;
                        carry_q  <= 1'b0;
                        lt_q     <= 1'b0;
                        gt_q     <= 1'b0;
                        eq_q     <= 1'b0;
                        div0_q   <= 1'b0;
                        case (bus.cmd_op)
                            OP_MUL:  state_q <= S_MUL;
                            OP_DIV:  state_q <= S_DIV;
                            default: state_q <= S_EXEC;
                        endcase
                    end
                end
                S_EXEC: begin
                    result_q    <= bus.alu_sum;
                    carry_q     <= bus.alu_c8;
                    lt_q        <= bus.alu_alb;
                    gt_q        <= bus.alu_agb;
                    eq_q        <= bus.alu_aeb;
                    res_valid_q <= 1'b1;
                    state_q     <= S_DONE;
                end
                S_MUL: begin
                    if (cnt_zero) begin
                        result_q    <= work_q;
                        carry_q     <= ovf_q;
                        res_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end else begin
                        work_q <= bus.alu_sum;
                        ovf_q  <= ovf_q | bus.alu_c8;
                    end
                end
                S_DIV: begin
                    if (b_q == '0) begin
                        div0_q      <= 1'b1;
                        result_q    <= DIV0_QUOTIENT;
                        rem_q       <= a_q;
                        res_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end else if (bus.alu_alb) begin
                        result_q    <= cnt_count;
                        rem_q       <= work_q;
                        res_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end else begin
                        work_q <= bus.alu_sum;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.res_valid = res_valid_q;
    assign bus.result    = result_q;
    assign bus.remainder = rem_q;
    assign bus.carry_ovf = carry_q;
    assign bus.cmp_lt    = lt_q;
    assign bus.cmp_gt    = gt_q;
    assign bus.cmp_eq    = eq_q;
    assign bus.err_div0  = div0_q;
    assign bus.busy      = (state_q != S_IDLE);

endmodule : calc_alu_sequencer
`default_nettype wire

// File: tb/tb_calc_alu_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_calc_alu_sequencer: directed + random commands against an arithmetic model
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_calc_alu_sequencer;

    logic clk;
    logic reset;
    int   errors;
    int   checks;

    calc_alu_sequencer_if bus ();

    calc_alu_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural stand-in for the external add/subtract ALU
    logic [8:0] alu_ext;
    assign alu_ext = bus.alu_add_sub ?
                     ({1'b0, bus.alu_a} + {1'b0, ~bus.alu_b} + 9'd1) :
                     ({1'b0, bus.alu_a} + {1'b0, bus.alu_b});
    assign bus.alu_sum = alu_ext[7:0];
    assign bus.alu_c8  = alu_ext[8];
    assign bus.alu_alb = (bus.alu_a <  bus.alu_b);
    assign bus.alu_agb = (bus.alu_a >  bus.alu_b);
    assign bus.alu_aeb = (bus.alu_a == bus.alu_b);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                         output logic [7:0] r, output logic [7:0] rem, output logic c,
                         output logic lt, output logic gt, output logic eq,
                         output logic d0, output int lat);
        int p;
        r = 0; rem = 0; c = 0; lt = 0; gt = 0; eq = 0; d0 = 0; lat = 2;
        case (op)
            2'd0: begin
                p  = int'(a) + int'(b);
                r  = p[7:0];
                c  = (p > 255);
                lt = (a < b); gt = (a > b); eq = (a == b);
            end
            2'd1: begin
                p  = int'(a) - int'(b);
                r  = p[7:0];
                c  = (a >= b);
                lt = (a < b); gt = (a > b); eq = (a == b);
            end
            2'd2: begin
                p   = int'(a) * int'(b);
                r   = p[7:0];
                c   = (p > 255);
                lat = 2 + int'(b);
            end
            default: begin
                if (b == 0) begin
                    r = 8'hFF; rem = a; d0 = 1;
                end else begin
                    r   = a / b;
                    rem = a % b;
                    lat = 2 + int'(a / b);
                end
            end
        endcase
    endtask

    task automatic run_cmd(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                           input bit hold);
        logic [7:0] er, erem;
        logic       ec, elt, egt, eeq, ed0;
        int         lat, k;
        bit         seen, bad_busy;
        logic [7:0] x_a, x_b, x_res;
        logic       x_as, x_flags;
        model(op, a, b, er, erem, ec, elt, egt, eeq, ed0, lat);
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_a     = a;
        bus.cmd_b     = b;
        check("ready_before", bus.cmd_ready, 1);
        @(posedge clk);
        #1;
        if (!hold) begin
            bus.cmd_valid = 1'b0;
            bus.cmd_a     = 8'($urandom);
            bus.cmd_b     = 8'($urandom);
        end
        seen = 0; bad_busy = 0; k = 0;
        x_a = 0; x_b = 0; x_as = 0; x_res = 0; x_flags = 0;
        while (!seen && k < 300) begin
            @(negedge clk);
            k++;
            if (k == 1) begin
                x_a = bus.alu_a; x_b = bus.alu_b; x_as = bus.alu_add_sub;
                x_res = bus.result;
                x_flags = bus.carry_ovf | bus.cmp_lt | bus.cmp_gt | bus.cmp_eq | bus.err_div0;
            end
            if (bus.res_valid) seen = 1;
            else if (!bus.busy || bus.cmd_ready) bad_busy = 1;
        end
        if (hold) bus.cmd_valid = 1'b0;
        check("res_valid_seen", seen, 1);
        check("latency", k, lat);
        check("busy_no_ready", bad_busy, 0);
        check("clear_on_accept", {x_res, x_flags}, 0);
        if (op[1] == 1'b0) begin
            check("alu_a_exec", x_a, a);
            check("alu_b_exec", x_b, b);
            check("alu_as_exec", x_as, op[0]);
        end
        check("result", bus.result, er);
        check("remainder", bus.remainder, erem);
        check("carry_ovf", bus.carry_ovf, ec);
        check("cmp", {bus.cmp_lt, bus.cmp_gt, bus.cmp_eq}, {elt, egt, eeq});
        check("err_div0", bus.err_div0, ed0);
        @(negedge clk);
        check("pulse_one_cycle", bus.res_valid, 0);
        check("idle_busy", bus.busy, 0);
        check("idle_ready", bus.cmd_ready, 1);
        check("idle_alu", {bus.alu_a, bus.alu_b, bus.alu_add_sub}, 0);
        check("result_hold", {bus.result, bus.remainder}, {er, erem});
    endtask

    initial begin
        bit         rv_seen;
        logic [1:0] rop;
        errors = 0;
        checks = 0;
        reset  = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'd0;
        bus.cmd_a     = 8'd0;
        bus.cmd_b     = 8'd0;
        repeat (3) @(negedge clk);
        check("rst_ready", bus.cmd_ready, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_outputs", {bus.res_valid, bus.result, bus.remainder, bus.carry_ovf,
                              bus.cmp_lt, bus.cmp_gt, bus.cmp_eq, bus.err_div0}, 0);
        check("rst_alu", {bus.alu_a, bus.alu_b, bus.alu_add_sub}, 0);
        reset = 1'b0;
        @(negedge clk);
        check("ready_after_rst", bus.cmd_ready, 1);

        run_cmd(2'd0, 8'h3F, 8'h3E, 0);
        run_cmd(2'd1, 8'h3F, 8'h40, 0);
        run_cmd(2'd1, 8'h3F, 8'h3F, 0);
        run_cmd(2'd0, 8'hF0, 8'h20, 0);
        run_cmd(2'd2, 8'h10, 8'h11, 0);
        run_cmd(2'd2, 8'h55, 8'h00, 0);
        run_cmd(2'd2, 8'h0F, 8'h11, 0);
        run_cmd(2'd3, 8'h64, 8'h07, 0);
        run_cmd(2'd3, 8'h05, 8'h09, 0);
        run_cmd(2'd3, 8'h2A, 8'h00, 1);
        run_cmd(2'd2, 8'h07, 8'h05, 1);

        for (int i = 0; i < 24; i++) begin
            rop = 2'($urandom_range(0, 3));
            run_cmd(rop, 8'($urandom), 8'($urandom), bit'($urandom_range(0, 1)));
        end

        // Reset in the middle of a long multiply
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 2'd2;
        bus.cmd_a     = 8'd3;
        bus.cmd_b     = 8'd200;
        check("mulrst_ready", bus.cmd_ready, 1);
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        rv_seen = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (bus.res_valid) rv_seen = 1;
            if (k == 10) reset = 1'b1;
        end
        #1;
        check("mulrst_ready_in_rst", bus.cmd_ready, 0);
        @(negedge clk);
        check("mulrst_busy", bus.busy, 0);
        check("mulrst_outputs", {bus.res_valid, bus.result, bus.remainder, bus.carry_ovf,
                                 bus.cmp_lt, bus.cmp_gt, bus.cmp_eq, bus.err_div0}, 0);
        check("mulrst_alu", {bus.alu_a, bus.alu_b, bus.alu_add_sub}, 0);
        reset = 1'b0;
        @(negedge clk);
        check("mulrst_ready_back", bus.cmd_ready, 1);
        for (int k = 0; k < 250; k++) begin
            @(negedge clk);
            if (bus.res_valid) rv_seen = 1;
        end
        check("mulrst_no_res_valid", rv_seen, 0);

        run_cmd(2'd0, 8'h01, 8'h02, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_calc_alu_sequencer
`default_nettype wire
